// File: rtl/inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : inst_axi_rd_bridge
// Brief    : Instruction-fetch SRAM-like responder to single-beat AXI4 reads.
//            Up to DEPTH fetches may be outstanding. Data returns in request
//            order because all reads use one ID.
//            Optional macro INST_AXI_FLUSH_EN adds a `flush` input. When
//            flush is asserted, the data of every fetch still in flight is
//            discarded.
// Revision : 1.0 - initial release
// ============================================================================
module inst_axi_rd_bridge #(
  parameter int         DEPTH  = 2,
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic        inst_cache,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arcache,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_AXI_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] cnt;
  logic          accept;
  logic          retire;
  logic          dec;
  logic          drop;
  logic          flush_now;

  // rid and rresp are deliberately ignored: one ID, errors forwarded as data
  logic unused_rsig;
  assign unused_rsig = &{1'b0, rid, rresp};

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign rready  = !reset;

  assign retire = rvalid && rready && rlast;
  // Never count below zero; stray beats are untracked
  assign dec    = retire && (cnt != '0);

  assign inst_sram_addr_ok = inst_sram_req && !inst_sram_wr && (cnt < DEPTH_C)
                             && (!arvalid || arready) && !flush_now;
  assign accept = inst_sram_addr_ok;

`ifdef INST_AXI_FLUSH_EN
  logic [CW-1:0] drop_cnt;

  assign flush_now = flush;
  assign drop      = retire && (drop_cnt != '0);

  // Count beats still owed to fetches that were killed by a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (flush) begin
      drop_cnt <= cnt - CW'(dec);
    end else if (drop) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end
`else
  assign flush_now = 1'b0;
  assign drop      = 1'b0;
`endif

  // Outstanding-fetch counter: accept and retire in one cycle cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(dec);
    end
  end

  // AR channel: load on accept, hold until arready, chain back-to-back
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'b010;
      arcache <= 4'b0000;
    end else if (accept) begin
      arvalid <= 1'b1;
      araddr  <= inst_sram_addr;
      arsize  <= {1'b0, inst_sram_size};
      arcache <= inst_cache ? 4'b1111 : 4'b0000;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // R channel: capture each delivered beat and pulse data_ok for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
    end else begin
      inst_sram_data_ok <= retire && !drop;
      if (retire && !drop) begin
        inst_sram_rdata <= rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_axi_rd_bridge
// Brief    : Scoreboard bench for inst_axi_rd_bridge. It runs directed fetch
//            scenarios and randomized traffic against a queue-based model of
//            pending AR requests, outstanding fetches and expected read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_axi_rd_bridge;

  localparam int         DEPTH  = 2;
  localparam logic [3:0] AXI_ID = 4'h5;

  typedef struct { logic [31:0] a; logic [2:0] sz; logic [3:0] ca; } ar_t;
  typedef struct { logic [31:0] d; int due; } rb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, cache;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ok, data_ok;
  logic [31:0] rdata_o;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata_i;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        flush_v;

  ar_t         arq[$];      // accepted requests whose AR is not yet handshaken
  rb_t         rq[$];       // AR-handshaken reads awaiting their R beat
  logic [31:0] dq[$];       // data expected on the next data_ok pulses
  logic [31:0] forced[$];   // fixed read data for directed scenarios
  int          beat_hist[$];
  int          outst, drop, cyc, n_acc, n_dok, last_acc_cyc, last_dok_cyc, acc_mark;
  bit          run, auto_drv, exp_dok;
  logic [31:0] last_data;
  int          p_req, p_wr, p_ar, p_r, dmin, dmax;
  int          vectors, fails;

  inst_axi_rd_bridge #(.DEPTH(DEPTH), .AXI_ID(AXI_ID)) dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_addr    (addr),
    .inst_cache        (cache),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
    .inst_sram_rdata   (rdata_o),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arcache           (arcache),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata_i),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
`ifdef INST_AXI_FLUSH_EN
    ,
    .flush             (flush_v)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    fails++;
    $display("FAIL %s: condition not reached (cycle %0d)", name, cyc);
  endtask

  // Reference model: checks the combinational/AR outputs, then advances state for the coming edge
  always @(negedge clk) begin
    logic exp_aok, hs, beat;
    ar_t  e;
    rb_t  b;
    if (run) begin
      exp_aok = req && !wr && (outst < DEPTH) && (arq.size() == 0 || arready) && !flush_v;
      chk("addr_ok", addr_ok, exp_aok);
      chk("arvalid", arvalid, arq.size() != 0);
      if (arq.size() != 0) begin
        chk("araddr", araddr, arq[0].a);
        chk("arsize", arsize, arq[0].sz);
        chk("arcache", arcache, arq[0].ca);
      end
      chk("data_ok", data_ok, exp_dok);
      chk("rready", rready, 1);
      chk("ar_const", {arid, arlen, arburst}, {AXI_ID, 8'h00, 2'b01});

      hs      = (arq.size() != 0) && arready;
      beat    = rvalid && rlast;
      exp_dok = 1'b0;
      if (beat) begin
        beat_hist.push_back(cyc);
        if (outst > 0) outst--;
        if (drop > 0) drop--;
        else begin
          exp_dok = 1'b1;
          dq.push_back(rdata_i);
        end
      end
      if (flush_v) drop = outst;
      if (hs) begin
        e    = arq.pop_front();
        b.d  = (forced.size() != 0) ? forced.pop_front() : $urandom;
        b.due = cyc + 1 + int'($urandom_range(dmax, dmin));
        rq.push_back(b);
      end
      if (exp_aok) begin
        e.a  = addr;
        e.sz = {1'b0, size};
        e.ca = cache ? 4'hf : 4'h0;
        arq.push_back(e);
        outst++;
        n_acc++;
        last_acc_cyc = cyc;
      end
    end
  end

  // Data monitor: every data_ok must carry the oldest expected read data
  always @(negedge clk) begin
    if (run) begin
      if (data_ok) begin
        n_dok++;
        last_dok_cyc = cyc;
        if (dq.size() == 0) fail_now("unexpected_data_ok");
        else last_data = dq.pop_front();
      end
      chk("rdata", rdata_o, last_data);
    end
  end

  // One clock: AXI slave responses plus optional random request driver
  task automatic tick();
    rb_t b;
    @(posedge clk);
    #1;
    cyc++;
    if (run) begin
      arready = ($urandom_range(99, 0) < p_ar);
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata_i = $urandom;
      if (rq.size() != 0 && rq[0].due <= cyc && $urandom_range(99, 0) < p_r) begin
        b       = rq.pop_front();
        rvalid  = 1'b1;
        rlast   = 1'b1;
        rdata_i = b.d;
        rid     = 4'($urandom);
        rresp   = 2'($urandom);
      end
      if (auto_drv) begin
        if (n_acc != acc_mark || !req || wr) begin
          req   = ($urandom_range(99, 0) < p_req);
          wr    = ($urandom_range(99, 0) < p_wr);
          addr  = $urandom & 32'hffff_fffc;
          size  = 2'($urandom_range(2, 0));
          cache = 1'($urandom);
        end
      end
      acc_mark = n_acc;
    end
  endtask

  task automatic wait_acc(input int m);
    for (int i = 0; i < 40 && n_acc == m; i++) tick();
    if (n_acc == m) fail_now("accept_timeout");
  endtask

  task automatic issue(input logic [31:0] a, input logic c, input logic [1:0] s);
    int m = n_acc;
    req = 1'b1; wr = 1'b0; addr = a; cache = c; size = s;
    wait_acc(m);
    req = 1'b0;
  endtask

  task automatic wait_idle();
    p_ar = 100; p_r = 100;
    for (int i = 0; i < 400 && (outst != 0 || dq.size() != 0 || arq.size() != 0); i++) tick();
    if (outst != 0 || dq.size() != 0 || arq.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic do_reset();
    run = 1'b0; reset = 1'b1; req = 1'b0; wr = 1'b0; flush_v = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arsize", arsize, 3'b010);
    chk("rst_arcache", arcache, 0);
    chk("rst_rready", rready, 0);
    arq.delete(); rq.delete(); dq.delete(); forced.delete(); beat_hist.delete();
    outst = 0; drop = 0; exp_dok = 1'b0; last_data = 32'd0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    run   = 1'b1;
  endtask

  task automatic random_phase(input int pq, input int pw, input int pa, input int pr,
                              input int lo, input int hi, input int n);
    p_req = pq; p_wr = pw; p_ar = pa; p_r = pr; dmin = lo; dmax = hi;
    auto_drv = 1'b1;
    repeat (n) tick();
    auto_drv = 1'b0;
    req = 1'b0;
  endtask

  initial begin
    int d0, m, a3;
    logic [31:0] v3;
    vectors = 0; fails = 0; cyc = 0; n_acc = 0; n_dok = 0; acc_mark = 0;
    last_acc_cyc = 0; last_dok_cyc = 0; auto_drv = 1'b0;
    size = 2'b10; addr = 32'd0; cache = 1'b0; rid = 4'd0; rresp = 2'd0; rdata_i = 32'd0;
    p_req = 0; p_wr = 0; p_ar = 100; p_r = 100; dmin = 0; dmax = 0;
    do_reset();

    // Single uncached fetch with immediate arready: data_ok three cycles after accept
    forced.push_back(32'h3c08bfc0);
    d0 = n_dok;
    issue(32'h1fc00000, 1'b0, 2'b10);
    for (int i = 0; i < 20 && n_dok == d0; i++) tick();
    if (n_dok == d0) fail_now("single_fetch_data_ok");
    else begin
      chk("single_latency", last_dok_cyc - last_acc_cyc, 3);
      chk("single_data", last_data, 32'h3c08bfc0);
    end
    wait_idle();

    // Three back-to-back fetches, R delayed 5: the third waits for the first beat
    dmin = 5; dmax = 5;
    beat_hist.delete();
    issue(32'h0000_1000, 1'b1, 2'b10);
    issue(32'h0000_1004, 1'b0, 2'b10);
    issue(32'h0000_1008, 1'b1, 2'b10);
    a3 = last_acc_cyc;
    if (beat_hist.size() == 0) fail_now("full_first_beat");
    else chk("full_resume_cycle", a3, beat_hist[0] + 1);
    wait_idle();

    // arready low for 4 cycles: AR held stable, second request not accepted
    dmin = 0; dmax = 2;
    p_ar = 0;
    issue(32'h2000_0040, 1'b1, 2'b01);
    m = n_acc;
    req = 1'b1; wr = 1'b0; addr = 32'h2000_0044; cache = 1'b0; size = 2'b10;
    repeat (4) tick();
    chk("stall_no_accept", n_acc, m);
    p_ar = 100;
    wait_acc(m);
    req = 1'b0;
    wait_idle();

    // Write requests are never acknowledged
    m = n_acc;
    req = 1'b1; wr = 1'b1; addr = 32'h3000_0000;
    repeat (10) tick();
    chk("wr_never_acked", n_acc, m);
    req = 1'b0; wr = 1'b0;

`ifdef INST_AXI_FLUSH_EN
    // Flush with two fetches in flight: only the post-flush fetch returns data
    wait_idle();
    dmin = 4; dmax = 4;
    v3 = 32'hcafe_0380;
    forced.push_back(32'h1111_1111);
    forced.push_back(32'h2222_2222);
    forced.push_back(v3);
    d0 = n_dok;
    issue(32'h0000_2000, 1'b0, 2'b10);
    issue(32'h0000_2004, 1'b0, 2'b10);
    m = n_acc;
    flush_v = 1'b1;
    req = 1'b1; wr = 1'b0; addr = 32'hbfc00380; cache = 1'b0; size = 2'b10;
    tick();
    chk("flush_blocks_accept", n_acc, m);
    flush_v = 1'b0;
    wait_acc(m);
    req = 1'b0;
    wait_idle();
    chk("flush_dok_count", n_dok - d0, 1);
    chk("flush_data", last_data, v3);
`else
    v3 = 32'd0;
`endif

    // Randomized traffic with varying backpressure and R delays
    wait_idle();
    random_phase(70, 10, 60, 70, 0, 3, 600);
    wait_idle();
    random_phase(95, 0, 100, 100, 0, 0, 400);
    wait_idle();
    random_phase(50, 20, 30, 40, 0, 8, 600);
    wait_idle();

    // Reset in the middle of traffic, then resume
    random_phase(80, 5, 70, 50, 2, 6, 40);
    do_reset();
    random_phase(70, 10, 60, 70, 0, 4, 300);
    wait_idle();
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
